// File: rtl/inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : inst_mem_responder
// Desc   : Read responder between an instruction-cache miss port and a
//          single-cycle SRAM, with up to two outstanding reads.
// Rev    : 1.0
// ============================================================================
module inst_mem_responder #(
  parameter int MEM_AW = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] CNT_MAX = 2'(DEPTH);

  logic        ar_hs;
  logic        r_hs;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic        pend;

  logic [31:0] fifo_mem [DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic [1:0]  fifo_cnt_nxt;
  logic        fifo_empty;

  logic        unused_addr_bits;

  assign ar_hs    = s_arvalid & s_arready;
  assign r_hs     = s_rvalid & s_rready;

  // SRAM is addressed in words; byte offset and upper bits wrap away
  assign mem_en   = ar_hs;
  assign mem_addr = s_araddr[MEM_AW+1:2];
  assign unused_addr_bits = ^{s_araddr[31:MEM_AW+2], s_araddr[1:0]};

  always_comb begin
    cnt_nxt = cnt;
    if (ar_hs && !r_hs) begin
      cnt_nxt = cnt + 2'd1;
    end else if (r_hs && !ar_hs) begin
      cnt_nxt = cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= 2'd0;
      s_arready <= 1'b0;
      pend      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      s_arready <= (cnt_nxt < CNT_MAX);
      pend      <= ar_hs;
    end
  end

  // Returning SRAM data is always captured; when the FIFO is empty it is also
  // presented directly so the first response costs only one cycle.
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign s_rvalid   = !fifo_empty || pend;
  assign s_rdata    = fifo_empty ? mem_rdata : fifo_mem[rd_ptr];

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({pend, r_hs})
      2'b10:   fifo_cnt_nxt = fifo_cnt + 2'd1;
      2'b01:   fifo_cnt_nxt = fifo_cnt - 2'd1;
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      fifo_cnt <= fifo_cnt_nxt;
      if (pend) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (r_hs) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pend) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
    cnt <= CNT_MAX);

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(pend && !r_hs && fifo_cnt == CNT_MAX));

  a_r_stable: assert property (@(posedge clk) disable iff (!resetn)
    (s_rvalid && !s_rready) |=> (s_rvalid && $stable(s_rdata)));

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_mem_responder
// Desc   : Directed vector table, reset corner case and randomised run against
//          a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_inst_mem_responder;

  logic        clk;
  logic        resetn;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_rready;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  inst_mem_responder #(.MEM_AW(12), .DEPTH(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [11:0] idx);
    if (idx == 12'd5) return 32'hDEADBEEF;
    return ({20'd0, idx} * 32'h9E3779B1) ^ 32'h5A5A0000 ^ {20'd0, idx};
  endfunction

  // SRAM: data one cycle after enable, garbage on idle cycles
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= sram_word(mem_addr);
    else        mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
    logic        exp_arready;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_mem_en;
    logic [11:0] exp_mem_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic arv, input logic [31:0] addr, input logic rr,
                              input logic e_ar, input logic e_rv, input logic [31:0] e_rd,
                              input logic e_me, input logic [11:0] e_ma);
    vec_t v;
    v.arvalid = arv; v.araddr = addr; v.rready = rr;
    v.exp_arready = e_ar; v.exp_rvalid = e_rv; v.exp_rdata = e_rd;
    v.exp_mem_en = e_me; v.exp_mem_addr = e_ma;
    return v;
  endfunction

  logic [31:0] exp_q[$];
  logic        exp_ar;
  logic        exp_rv;

  initial begin
    // Single read of word 5 with minimum latency
    vecs.push_back(mk(1, 32'h14,   1, 1, 0, 32'h0,         1, 12'd5));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, 32'hDEADBEEF,  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 0, 32'h0,         0, 12'd0));
    // Stalled consumer fills both slots, then drains in order
    vecs.push_back(mk(1, 32'h0,    0, 1, 0, 32'h0,         1, 12'd0));
    vecs.push_back(mk(1, 32'h4,    0, 1, 1, sram_word(0),  1, 12'd1));
    vecs.push_back(mk(1, 32'h8,    0, 0, 1, sram_word(0),  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, sram_word(0),  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, sram_word(1),  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 0, 32'h0,         0, 12'd0));
    // Back-to-back reads, one response per cycle
    vecs.push_back(mk(1, 32'h0,    1, 1, 0, 32'h0,         1, 12'd0));
    vecs.push_back(mk(1, 32'h4,    1, 1, 1, sram_word(0),  1, 12'd1));
    vecs.push_back(mk(1, 32'h8,    1, 1, 1, sram_word(1),  1, 12'd2));
    vecs.push_back(mk(1, 32'hC,    1, 1, 1, sram_word(2),  1, 12'd3));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, sram_word(3),  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 0, 32'h0,         0, 12'd0));
    // Address wrap: 0x4003 maps to word 0
    vecs.push_back(mk(1, 32'h4003, 1, 1, 0, 32'h0,         1, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, sram_word(0),  0, 12'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 0, 32'h0,         0, 12'd0));

    resetn = 1'b0; s_arvalid = 1'b1; s_araddr = 32'h14; s_rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_arready", {31'd0, s_arready}, 32'd0);
    chk("reset_rvalid",  {31'd0, s_rvalid},  32'd0);
    chk("reset_mem_en",  {31'd0, mem_en},    32'd0);

    @(posedge clk); #1;
    resetn = 1'b1; s_arvalid = 1'b0;
    @(negedge clk);
    chk("arready_before_first_edge", {31'd0, s_arready}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      s_arvalid = vecs[i].arvalid; s_araddr = vecs[i].araddr; s_rready = vecs[i].rready;
      @(negedge clk);
      chk($sformatf("vec%0d_arready", i), {31'd0, s_arready}, {31'd0, vecs[i].exp_arready});
      chk($sformatf("vec%0d_rvalid", i),  {31'd0, s_rvalid},  {31'd0, vecs[i].exp_rvalid});
      chk($sformatf("vec%0d_mem_en", i),  {31'd0, mem_en},    {31'd0, vecs[i].exp_mem_en});
      if (vecs[i].exp_rvalid)
        chk($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_mem_en)
        chk($sformatf("vec%0d_mem_addr", i), {20'd0, mem_addr}, {20'd0, vecs[i].exp_mem_addr});
    end

    // Reset with two responses outstanding: nothing may survive it
    @(posedge clk); #1;
    s_arvalid = 1'b1; s_araddr = 32'h8; s_rready = 1'b0;
    @(posedge clk); #1;
    s_araddr = 32'hC;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid_pre",  {31'd0, s_rvalid},  32'd1);
    chk("mid_rdata_pre",   s_rdata,            sram_word(2));
    chk("mid_arready_pre", {31'd0, s_arready}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0; s_arvalid = 1'b1;
    #1;
    chk("mid_rst_rvalid",  {31'd0, s_rvalid},  32'd0);
    chk("mid_rst_arready", {31'd0, s_arready}, 32'd0);
    chk("mid_rst_mem_en",  {31'd0, mem_en},    32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; s_arvalid = 1'b0; s_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("post_rst%0d_rvalid", k), {31'd0, s_rvalid}, 32'd0);
    end
    chk("post_rst_arready", {31'd0, s_arready}, 32'd1);

    // Randomised run against an in-order queue of expected words
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      s_arvalid = ($urandom_range(0, 3) != 0);
      s_araddr  = $urandom;
      s_rready  = ($urandom_range(0, 2) != 0);
      if ((c % 1000) > 960) s_rready = 1'b0;
      if ((c % 1000) < 40) begin
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
      end
      @(negedge clk);
      exp_ar = (exp_q.size() < 2);
      exp_rv = (exp_q.size() > 0);
      chk("rnd_arready", {31'd0, s_arready}, {31'd0, exp_ar});
      chk("rnd_rvalid",  {31'd0, s_rvalid},  {31'd0, exp_rv});
      chk("rnd_mem_en",  {31'd0, mem_en},    {31'd0, s_arvalid && exp_ar});
      if (exp_rv)
        chk("rnd_rdata", s_rdata, exp_q[0]);
      if (s_arvalid && exp_ar)
        chk("rnd_mem_addr", {20'd0, mem_addr}, (s_araddr >> 2) % 4096);
      if (exp_rv && s_rready)
        void'(exp_q.pop_front());
      if (s_arvalid && exp_ar)
        exp_q.push_back(sram_word(12'((s_araddr >> 2) % 4096)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter MEM_AW, default 12: word-address width of the backing SRAM (4096 words).
REQ-002 Parameter DEPTH, fixed 2: maximum outstanding read requests; other values are not supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 s_araddr  input  32  byte read address from the initiator (cache miss path).
REQ-006 s_arvalid  input  1  read request valid.
REQ-007 s_arready  output  1  responder can accept a request.
REQ-008 s_rdata  output  32  read data word.
REQ-009 s_rvalid  output  1  read data valid.
REQ-010 s_rready  input  1  initiator accepts read data.
REQ-011 mem_en  output  1  SRAM read enable.
REQ-012 mem_addr  output  MEM_AW  SRAM word address.
REQ-013 mem_rdata  input  32  SRAM data, valid exactly one cycle after mem_en=1.

Function
REQ-014 An AR handshake occurs in any cycle with s_arvalid=1 and s_arready=1; an R handshake occurs in any cycle with s_rvalid=1 and s_rready=1.
REQ-015 The block SHALL keep counter cnt (0..2) = requests accepted minus responses delivered; cnt SHALL be +1 on an AR-only cycle, -1 on an R-only cycle, and unchanged when both handshakes occur in the same cycle.
REQ-016 s_arready SHALL be a register whose next value is 1 when next cnt < 2, else 0.
REQ-017 In an AR-handshake cycle, mem_en SHALL be 1 and mem_addr SHALL equal s_araddr[MEM_AW+1:2] combinationally; otherwise mem_en SHALL be 0.
REQ-018 s_araddr[1:0] and bits above MEM_AW+1 SHALL be ignored; addresses wrap modulo the SRAM size.
REQ-019 A one-bit register pend SHALL be 1 in the cycle after each AR handshake; when pend=1, mem_rdata SHALL be written into a 2-entry in-order response FIFO in that cycle.
REQ-020 s_rvalid SHALL be 1 whenever the FIFO is non-empty; s_rdata SHALL be the FIFO head; an R handshake SHALL pop the head.
REQ-021 Minimum latency: AR handshake in cycle N -> s_rvalid=1 with the correct data in cycle N+1 (FIFO write-through of mem_rdata when empty, or a registered path with latency N+2; the implementation SHALL choose N+1).
REQ-022 Responses SHALL be returned strictly in request order.
REQ-023 Once asserted, s_rvalid and s_rdata SHALL remain stable until the R handshake.
REQ-024 Push and pop in the same cycle SHALL both take effect; the FIFO SHALL never overflow, because cnt <= 2 bounds buffered plus in-flight data.
REQ-025 s_rready=0 indefinitely SHALL hold the data, drive s_arready=0 once cnt=2, and not corrupt FIFO contents.
REQ-026 Sustained s_arvalid=1 with s_rready=1 SHALL sustain one AR and one R handshake per cycle after the first response.

Reset
REQ-027 While resetn=0: cnt=0, pend=0, FIFO empty, s_rvalid=0, s_arready=0, mem_en=0.
REQ-028 On the first rising edge after resetn deasserts, s_arready SHALL become 1.
REQ-029 Assertion of resetn mid-operation SHALL discard all outstanding requests and buffered data, with no response issued for them afterwards.

Verification
REQ-030 SRAM word 5=0xDEADBEEF; AR of 0x14 at cycle N with s_rready=1 -> mem_en=1 and mem_addr=5 at N; s_rvalid=1 and s_rdata=0xDEADBEEF at N+1.
REQ-031 s_rready=0; AR of 0x0 and then 0x4 -> s_arready=0 after the second handshake; raise s_rready -> words 0 and 1 delivered in order; s_arready returns to 1.
REQ-032 Back-to-back ARs of 0x0, 0x4, 0x8, 0xC with s_rready=1 -> one response per cycle from N+1 to N+4, in order, with no bubbles.
REQ-033 AR of 0x4003 with MEM_AW=12 -> mem_addr=0x000; the data returned is word 0.
REQ-034 Two requests outstanding with s_rvalid=1, then pulse resetn low -> s_rvalid=0 and s_arready=0 immediately; after release, no stale response appears.
REQ-035 Randomised s_arvalid/s_rready for 10k cycles against a reference model -> data matches in order, cnt never exceeds 2, and there are no handshake stability violations.
